// File: rtl/cyc_fifo_mc.sv
// Multi-channel cyclic weight FIFO: loads a block of cfg_len words and replays it cfg_rep times.
// Define CYC_FIFO_MC_STREAM_EN to make pass 0 readable while the block is still loading.
module cyc_fifo_mc #(
    parameter int DW    = 32,
    parameter int DEPTH = 9,
    parameter int CH    = 4,
    parameter int RW    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
    input  logic [RW-1:0]                cfg_rep,
    input  logic                         i_valid,
    input  logic [CH*DW-1:0]             i_data,
    output logic                         full,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [CH*DW-1:0]             o_data,
    output logic                         o_last,
    output logic                         o_done,
    output logic                         empty,
    output logic                         busy
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = CH * DW;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [LW-1:0] r_len, w_len_nxt;
    logic [RW-1:0] r_rep, w_rep_nxt;
    logic [RW-1:0] r_pass, w_pass_nxt;
    logic [PW-1:0] r_wr, w_wr_nxt;
    logic [PW-1:0] r_rd, w_rd_nxt;
    logic [WW-1:0] r_data, w_data_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_last, w_last_nxt;
    logic          r_done, w_done_nxt;
    logic          r_full, r_empty, r_busy;
    logic          w_we, w_cfg_ok, w_xfer, w_rd_wrap, w_final;
    logic [PW-1:0] w_len_end, w_rd_inc;
    logic [WW-1:0] r_mem [DEPTH];

    assign w_cfg_ok  = cfg_start && (cfg_len != {LW{1'b0}}) && (cfg_len <= LEN_MAX)
                       && (cfg_rep != {RW{1'b0}});
    assign w_len_end = PW'(r_len - LW'(1));
    assign w_xfer    = r_valid && o_ready;
    assign w_rd_wrap = (r_rd == w_len_end);
    // Explicit wrap at len-1 so non power-of-two depths cycle correctly
    assign w_rd_inc  = w_rd_wrap ? {PW{1'b0}} : (r_rd + PW'(1));
    assign w_final   = w_rd_wrap && (r_pass == (r_rep - RW'(1)));

    assign full    = r_full;
    assign empty   = r_empty;
    assign busy    = r_busy;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_done  = r_done;

    // Block storage, shared pointers for all channels; intentionally not reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_rep_nxt   = r_rep;
        w_pass_nxt  = r_pass;
        w_wr_nxt    = r_wr;
        w_rd_nxt    = r_rd;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_ok) begin
                    w_len_nxt   = cfg_len;
                    w_rep_nxt   = cfg_rep;
                    w_wr_nxt    = {PW{1'b0}};
                    w_rd_nxt    = {PW{1'b0}};
                    w_pass_nxt  = {RW{1'b0}};
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
`ifdef CYC_FIFO_MC_STREAM_EN
                // Pass 0 drains behind the writer; rd never reaches len-1 while loading
                if (r_valid) begin
                    if (o_ready) begin
                        w_rd_nxt = r_rd + PW'(1);
                        if ((r_rd + PW'(1)) < r_wr) begin
                            w_data_nxt = r_mem[r_rd + PW'(1)];
                            w_last_nxt = ((r_rd + PW'(1)) == w_len_end);
                        end else begin
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_rd_nxt = r_rd;
                    end
                end else if (r_rd < r_wr) begin
                    w_data_nxt  = r_mem[r_rd];
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_rd == w_len_end);
                end else begin
                    w_valid_nxt = 1'b0;
                end
`else
                w_valid_nxt = 1'b0;
`endif
                if (i_valid) begin
                    w_we     = 1'b1;
                    w_wr_nxt = r_wr + PW'(1);
                    if (r_wr == w_len_end) begin
                        w_state_nxt = ST_REPLAY;
`ifdef CYC_FIFO_MC_STREAM_EN
                        w_rd_nxt = w_rd_nxt;
`else
                        // A one-word block has word 0 on i_data this very cycle
                        w_data_nxt  = (w_len_end == {PW{1'b0}}) ? i_data : r_mem[0];
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (w_len_end == {PW{1'b0}});
`endif
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_we = 1'b0;
                end
            end
            ST_REPLAY: begin
`ifdef CYC_FIFO_MC_STREAM_EN
                if (!r_valid) begin
                    w_data_nxt  = r_mem[r_rd];
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_rd == w_len_end);
                end else begin
                    w_valid_nxt = 1'b1;
                end
`else
                w_valid_nxt = r_valid;
`endif
                if (w_xfer) begin
                    if (w_final) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rd_nxt   = w_rd_inc;
                        w_pass_nxt = w_rd_wrap ? (r_pass + RW'(1)) : r_pass;
                        w_data_nxt = r_mem[w_rd_inc];
                        w_last_nxt = (w_rd_inc == w_len_end);
                    end
                end else begin
                    w_state_nxt = ST_REPLAY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= {LW{1'b0}};
            r_rep   <= {RW{1'b0}};
            r_pass  <= {RW{1'b0}};
            r_wr    <= {PW{1'b0}};
            r_rd    <= {PW{1'b0}};
            r_data  <= {WW{1'b0}};
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_full  <= 1'b1;
            r_empty <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_len   <= w_len_nxt;
            r_rep   <= w_rep_nxt;
            r_pass  <= w_pass_nxt;
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            r_full  <= (w_state_nxt != ST_LOAD);
            r_empty <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
